// File: rtl/pixel_xor_stage.sv
`default_nettype none
// ============================================================================
// Module      : pixel_xor_stage
// Description : Streaming RGB pixel stage that XORs each pixel with the
//               current keystream bytes (or passes it through in bypass),
//               tracks frame position, and buffers results in a 2-entry
//               output FIFO.
// Ports       : clk, rst            - clock, async active-high reset
//               en                  - encrypt enable, sampled at frame start
//               ks_r/ks_g/ks_b      - current keystream bytes
//               ks_adv              - step the keystream generator
//               in_valid/in_ready   - input handshake
//               in_sof, in_r/g/b    - input pixel, first-of-frame marker
//               out_valid/out_ready - output handshake
//               out_sof/out_eol     - output frame-start / end-of-line marks
//               out_r/g/b           - output pixel
//               err_clr, frame_err  - sticky early-frame-start flag + clear
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_xor_stage #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] ks_r,
  input  logic [7:0] ks_g,
  input  logic [7:0] ks_b,
  output logic       ks_adv,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sof,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eol,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  input  logic       err_clr,
  output logic       frame_err
);

  // A 1-pixel dimension still needs a 1-bit counter to be legal.
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam int EW = 26;  // {sof, eol, r, g, b}

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [XW-1:0] x, x_nxt, pos_x;
  logic [YW-1:0] y, y_nxt, pos_y;
  logic          enc_lat, enc_lat_nxt;

  logic          accept, push, pop, start, at_last, early_sof;
  logic          line_end, enc_now;
  logic [EW-1:0] push_data;

  logic [EW-1:0] mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;

  assign accept  = in_valid & in_ready;
  assign at_last = (x == X_LAST) && (y == Y_LAST);

  // An sof on the last pixel of a frame just closes that frame; any other
  // accepted sof (re)starts at pixel (0,0).
  assign start     = accept & in_sof & ((state == ST_IDLE) | ~at_last);
  assign early_sof = start & (state == ST_ACTIVE);
  assign push      = accept & ((state == ST_ACTIVE) | in_sof);
  assign pop       = out_valid & out_ready;

  // Position of the pixel being accepted this cycle.
  assign pos_x    = start ? '0 : x;
  assign pos_y    = start ? '0 : y;
  assign line_end = (pos_x == X_LAST);

  // The sof pixel uses en directly since enc_lat only updates at the edge.
  assign enc_now = start ? en : enc_lat;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      x       <= '0;
      y       <= '0;
      enc_lat <= 1'b0;
    end else begin
      state   <= state_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      enc_lat <= enc_lat_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    x_nxt       = x;
    y_nxt       = y;
    enc_lat_nxt = enc_lat;
    if (push) begin
      if (start) begin
        enc_lat_nxt = en;
      end
      if (line_end) begin
        x_nxt = '0;
        if (pos_y == Y_LAST) begin
          y_nxt     = '0;
          state_nxt = ST_IDLE;
        end else begin
          y_nxt     = pos_y + YW'(1);
          state_nxt = ST_ACTIVE;
        end
      end else begin
        x_nxt     = pos_x + XW'(1);
        y_nxt     = pos_y;
        state_nxt = ST_ACTIVE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Held low during reset; a full buffer can still take a pixel when the
    // head is leaving in the same cycle.
    in_ready  = ~rst & ((count != 2'd2) | out_ready);
    ks_adv    = push & enc_now;
    push_data = {start, line_end,
                 in_r ^ (enc_now ? ks_r : 8'h00),
                 in_g ^ (enc_now ? ks_g : 8'h00),
                 in_b ^ (enc_now ? ks_b : 8'h00)};
  end

  // --------------------------------------------------------------------------
  // Sticky overrun flag; a new set beats a simultaneous clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (early_sof) begin
      frame_err <= 1'b1;
    end else if (err_clr) begin
      frame_err <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry output FIFO. Storage is cleared on reset so the outputs read 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign {out_sof, out_eol, out_r, out_g, out_b} = mem[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_pixel_xor_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_xor_stage
// Description : Self-checking bench for pixel_xor_stage (4x2 frame). Driver
//               pushes expected output beats into a queue; a monitor pops and
//               compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_xor_stage;

  logic       clk, rst, en, ks_adv, in_valid, in_ready, in_sof;
  logic [7:0] ks_r, ks_g, ks_b, in_r, in_g, in_b, out_r, out_g, out_b;
  logic       out_valid, out_ready, out_sof, out_eol, err_clr, frame_err;

  typedef logic [25:0] ent_t;
  ent_t sb[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   gen_idx = 0;
  int   exp_idx = 0;

  pixel_xor_stage #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .ks_r(ks_r), .ks_g(ks_g), .ks_b(ks_b), .ks_adv(ks_adv),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .out_eol(out_eol), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .err_clr(err_clr), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keystream generator stand-in: index 0 gives (0x21, 0x3F, 0x0B).
  function automatic logic [23:0] ks_at(input int i);
    logic [7:0] r, g, b;
    r = 8'h21 + 8'(i * 37);
    g = 8'h3F + 8'(i * 11);
    b = 8'h0B + 8'(i * 5);
    return {r, g, b};
  endfunction

  always @(posedge clk) if (ks_adv) gen_idx <= gen_idx + 1;
  assign {ks_r, ks_g, ks_b} = ks_at(gen_idx);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      ncmp++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL out_unexpected: got %h expected nothing",
                 {out_sof, out_eol, out_r, out_g, out_b});
      end else begin
        ent_t e;
        e = sb.pop_front();
        if ({out_sof, out_eol, out_r, out_g, out_b} !== e) begin
          nerr++;
          $display("FAIL out_data: got %h expected %h",
                   {out_sof, out_eol, out_r, out_g, out_b}, e);
        end
      end
    end
  end

  // Offer one pixel, wait (bounded) for in_ready, check ks_adv, record output.
  task automatic send(input logic sof, input logic [7:0] r, g, b,
                      input logic epush, input logic eadv,
                      input logic esof, input logic eeol,
                      input logic [7:0] er, eg, eb);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_sof = sof; in_r = r; in_g = g; in_b = b;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("in_ready_timeout", 32'(ok), 32'd1);
    chk("ks_adv", 32'(ks_adv), 32'(eadv));
    if (epush) sb.push_back({esof, eeol, er, eg, eb});
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic pix(input logic sof, input int seed, input logic epush,
                     input logic enc, input logic esof, input logic eeol);
    logic [23:0] k;
    logic [7:0]  r, g, b;
    r = 8'(seed * 13 + 7);
    g = 8'(seed * 29 + 100);
    b = 8'(~seed);
    k = (epush && enc) ? ks_at(exp_idx) : 24'h0;
    send(sof, r, g, b, epush, epush & enc, esof, eeol,
         r ^ k[23:16], g ^ k[15:8], b ^ k[7:0]);
    if (epush && enc) exp_idx++;
  endtask

  initial begin
    int acc;
    bit drained;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    in_r = 8'h00; in_g = 8'h00; in_b = 8'h00; out_ready = 1'b1; err_clr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_outs", {out_sof, out_eol, out_r, out_g, out_b}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Encrypted sof pixel, hand-computed result, one-cycle latency
    en = 1'b1;
    send(1'b1, 8'hFF, 8'h00, 8'h0B, 1'b1, 1'b1, 1'b1, 1'b0, 8'hDE, 8'h3F, 8'h00);
    exp_idx++;
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("ks_adv_one_cycle", 32'(ks_adv), 32'd0);
    @(posedge clk); #1;
    for (int i = 1; i < 8; i++) pix(1'b0, i, 1'b1, 1'b1, 1'b0, (i % 4) == 3);
    // Frame done: stray non-sof pixels are dropped
    pix(1'b0, 50, 1'b0, 1'b0, 1'b0, 1'b0);
    pix(1'b0, 51, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bypass frame; en toggled mid-frame must not matter
    en = 1'b0;
    pix(1'b1, 60, 1'b1, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    for (int i = 1; i < 8; i++) pix(1'b0, 60 + i, 1'b1, 1'b0, 1'b0, (i % 4) == 3);
    pix(1'b0, 70, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-pressure: stream with out_ready low, only 2 accepted
    en = 1'b0; out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_sof = (acc == 0);
      in_r = 8'(80 + acc); in_g = 8'(90 + acc); in_b = 8'(100 + acc);
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({(acc == 0), 1'b0, 8'(80 + acc), 8'(90 + acc), 8'(100 + acc)});
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    chk("stall_accepts", 32'(acc), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int i = 2; i < 8; i++) pix(1'b0, 110 + i, 1'b1, 1'b0, 1'b0, (i % 4) == 3);

    // Early sof: error flagged, frame restarts at 0
    en = 1'b1;
    pix(1'b1, 120, 1'b1, 1'b1, 1'b1, 1'b0);
    pix(1'b0, 121, 1'b1, 1'b1, 1'b0, 1'b0);
    pix(1'b0, 122, 1'b1, 1'b1, 1'b0, 1'b0);
    pix(1'b1, 123, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("early_sof_err", 32'(frame_err), 32'd1);
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) pix(1'b0, 123 + i, 1'b1, 1'b1, 1'b0, i == 3);
    // Another early sof together with err_clr: set wins
    err_clr = 1'b1;
    pix(1'b1, 130, 1'b1, 1'b1, 1'b1, 1'b0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("set_beats_clr", 32'(frame_err), 32'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    // sof on the final pixel closes the frame without error (uses enc_lat)
    for (int i = 1; i < 7; i++) pix(1'b0, 130 + i, 1'b1, 1'b1, 1'b0, (i % 4) == 3);
    en = 1'b0;
    pix(1'b1, 137, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("last_sof_no_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    pix(1'b0, 140, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with 2 pixels buffered
    out_ready = 1'b0;
    pix(1'b1, 150, 1'b1, 1'b0, 1'b1, 1'b0);
    pix(1'b0, 151, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    pix(1'b0, 160, 1'b0, 1'b0, 1'b0, 1'b0);
    pix(1'b1, 161, 1'b1, 1'b0, 1'b1, 1'b0);

    // Drain and confirm nothing expected is left over
    drained = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (sb.size() == 0 && !out_valid) begin drained = 1; break; end
    end
    chk("drain", 32'(drained), 32'd1);
    chk("ks_index", 32'(gen_idx), 32'(exp_idx));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
